half_adder_seq: RTL and testbench

HALF_ADDER_SEQ -- requirements
Module: half_adder_seq

---
 rtl/half_adder_seq.sv | 91 +++++++++
 tb/tb_half_adder_seq.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/half_adder_seq.sv
// Sequential adder: sums two W-bit operands by repeated bitwise half-add steps
// (x^y, carries shifted left) until no carries remain, with valid/ready handshakes.
module half_adder_seq #(
    parameter int W      = 4,
    parameter int ITER_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W-1:0]      a,
    input  logic [W-1:0]      b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W:0]        sum,
    output logic [ITER_W-1:0] iter
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t              state_q;
    logic [W:0]          x_q;
    logic [W:0]          y_q;
    logic [W:0]          x_d;
    logic [W:0]          y_d;
    logic [ITER_W-1:0]   cnt_q;
    logic [W:0]          sum_q;
    logic [ITER_W-1:0]   iter_q;
    logic                out_valid_q;

    // One half-add step; the carry leaving the MSB of the working width is dropped.
    assign x_d = x_q ^ y_q;
    assign y_d = {x_q[W-1:0] & y_q[W-1:0], 1'b0};

    // in_ready must already be low in a cycle where reset is asserted.
    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign iter      = iter_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            cnt_q       <= '0;
            sum_q       <= '0;
            iter_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        x_q     <= {1'b0, a};
                        y_q     <= {1'b0, b};
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (y_q != '0) begin
                        x_q   <= x_d;
                        y_q   <= y_d;
                        cnt_q <= cnt_q + ITER_W'(1);
                    end else begin
                        sum_q       <= x_q;
                        iter_q      <= cnt_q;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    // Result registers are left untouched so they stay readable after the handshake.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_half_adder_seq.sv
// Scoreboard bench for half_adder_seq: directed spec vectors, backpressure,
// reset abort and an exhaustive operand sweep with random out_ready.
module tb_half_adder_seq;

    localparam int W      = 4;
    localparam int ITER_W = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [W-1:0]      a;
    logic [W-1:0]      b;
    logic              out_valid;
    logic              out_ready;
    logic [W:0]        sum;
    logic [ITER_W-1:0] iter;

    typedef struct {
        logic [W:0]        s;
        logic [ITER_W-1:0] it;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    half_adder_seq #(.W(W), .ITER_W(ITER_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .iter      (iter)
    );

    // Reference step count: repeat carry-save until no carry is left.
    function automatic logic [ITER_W-1:0] model_iter(input logic [W-1:0] aa, input logic [W-1:0] bb);
        logic [W:0]   x;
        logic [W:0]   y;
        logic [W+1:0] c;
        int           n;
        x = {1'b0, aa};
        y = {1'b0, bb};
        n = 0;
        while (y != 0 && n < 16) begin
            c = {1'b0, (x & y)} << 1;
            x = x ^ y;
            y = c[W:0];
            n++;
        end
        return ITER_W'(n);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [W:0] s, input logic [ITER_W-1:0] it);
        exp_t e;
        e.s  = s;
        e.it = it;
        sb.push_back(e);
    endtask

    // Offers one operand pair for a single edge, then scrambles a/b.
    task automatic issue(input logic [W-1:0] aa, input logic [W-1:0] bb);
        a        = aa;
        b        = bb;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a        = ~aa;
        b        = ~bb;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b1;
        a         = 4'd3;
        b         = 4'd4;
        out_ready = 1'b0;
        tick();
        tick();
        vectors++;
        if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        vectors++;
        if (sum !== 5'd0) begin miscompares++; $display("FAIL reset_sum: got %b want 00000", sum); end
        vectors++;
        if (iter !== 3'd0) begin miscompares++; $display("FAIL reset_iter: got %0d want 0", iter); end
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_release_in_ready: got %b want 1", in_ready); end
        tick();
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_valid_ignored: in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_zero();
        int   lat;
        exp_t e;
        out_ready = 1'b1;
        issue(4'd0, 4'd0);
        push(5'b00000, 3'd0);
        wait_out(lat);
        e = sb.pop_front();
        vectors++;
        if (lat !== 1) begin miscompares++; $display("FAIL zero_latency: got %0d want 1", lat); end
        vectors++;
        if (sum !== e.s) begin miscompares++; $display("FAIL zero_sum: got %b want %b", sum, e.s); end
        vectors++;
        if (iter !== e.it) begin miscompares++; $display("FAIL zero_iter: got %0d want %0d", iter, e.it); end
        tick();
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL zero_single_cycle_valid: got %b want 0", out_valid); end
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL zero_back_idle: in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_small();
        int   lat;
        exp_t e;
        out_ready = 1'b1;
        issue(4'd1, 4'd1);
        push(5'b00010, 3'd2);
        wait_out(lat);
        e = sb.pop_front();
        vectors++;
        if (lat !== 3) begin miscompares++; $display("FAIL small_latency: got %0d want 3", lat); end
        vectors++;
        if (sum !== e.s) begin miscompares++; $display("FAIL small_sum: got %b want %b", sum, e.s); end
        vectors++;
        if (iter !== e.it) begin miscompares++; $display("FAIL small_iter: got %0d want %0d", iter, e.it); end
        tick();
    endtask

    task automatic test_carry_chain();
        int   lat;
        exp_t e;
        out_ready = 1'b1;
        issue(4'd15, 4'd1);
        push(5'b10000, 3'd5);
        wait_out(lat);
        e = sb.pop_front();
        vectors++;
        if (lat !== 6) begin miscompares++; $display("FAIL chain_latency: got %0d want 6", lat); end
        vectors++;
        if (sum !== e.s) begin miscompares++; $display("FAIL chain_sum: got %b want %b", sum, e.s); end
        vectors++;
        if (iter !== e.it) begin miscompares++; $display("FAIL chain_iter: got %0d want %0d", iter, e.it); end
        tick();
        issue(4'd15, 4'd15);
        push(5'b11110, 3'd2);
        wait_out(lat);
        e = sb.pop_front();
        vectors++;
        if (lat !== 3) begin miscompares++; $display("FAIL max_latency: got %0d want 3", lat); end
        vectors++;
        if (sum !== e.s) begin miscompares++; $display("FAIL max_sum: got %b want %b", sum, e.s); end
        vectors++;
        if (iter !== e.it) begin miscompares++; $display("FAIL max_iter: got %0d want %0d", iter, e.it); end
        tick();
    endtask

    task automatic test_backpressure();
        int   lat;
        exp_t e;
        out_ready = 1'b0;
        issue(4'd5, 4'd3);
        push(5'b01000, 3'd4);
        wait_out(lat);
        e = sb.pop_front();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a        = 4'd9;
            b        = 4'd0;
            vectors++;
            if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_valid_held[%0d]: got %b want 1", i, out_valid); end
            vectors++;
            if (sum !== e.s) begin miscompares++; $display("FAIL bp_sum_stable[%0d]: got %b want %b", i, sum, e.s); end
            vectors++;
            if (iter !== e.it) begin miscompares++; $display("FAIL bp_iter_stable[%0d]: got %0d want %0d", i, iter, e.it); end
            vectors++;
            if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); end
            tick();
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_release_valid: got %b want 0", out_valid); end
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_no_same_edge_accept: in_ready got %b want 1", in_ready); end
        vectors++;
        if (sum !== e.s) begin miscompares++; $display("FAIL bp_sum_retained: got %b want %b", sum, e.s); end
        tick();
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_a9_not_captured: in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_reset_mid_run();
        out_ready = 1'b1;
        issue(4'd15, 4'd1);
        tick();
        rst = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin miscompares++; $display("FAIL midrst_in_ready_during: got %b want 0", in_ready); end
        tick();
        rst = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
        vectors++;
        if (sum !== 5'd0) begin miscompares++; $display("FAIL midrst_sum: got %b want 00000", sum); end
        vectors++;
        if (iter !== 3'd0) begin miscompares++; $display("FAIL midrst_iter: got %0d want 0", iter); end
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL midrst_in_ready: got %b want 1", in_ready); end
        for (int i = 0; i < 8; i++) begin
            tick();
            vectors++;
            if (out_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_stale_result[%0d]: out_valid got %b want 0", i, out_valid); end
        end
    endtask

    task automatic test_back_to_back();
        int         lat;
        int         guard;
        exp_t       e;
        logic [W:0] hold;
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                out_ready = 1'($urandom_range(0, 1));
                vectors++;
                if (in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_in_ready a=%0d b=%0d: got %b want 1", ai, bi, in_ready); end
                issue(W'(ai), W'(bi));
                push(5'(ai + bi), model_iter(W'(ai), W'(bi)));
                wait_out(lat);
                e = sb.pop_front();
                vectors++;
                if (sum !== e.s) begin miscompares++; $display("FAIL b2b_sum a=%0d b=%0d: got %0d want %0d", ai, bi, sum, e.s); end
                vectors++;
                if (iter !== e.it || iter > 3'(W + 1)) begin miscompares++; $display("FAIL b2b_iter a=%0d b=%0d: got %0d want %0d", ai, bi, iter, e.it); end
                vectors++;
                if (lat !== int'(iter) + 1) begin miscompares++; $display("FAIL b2b_latency a=%0d b=%0d: got %0d want %0d", ai, bi, lat, int'(iter) + 1); end
                hold  = sum;
                guard = 0;
                while (out_valid === 1'b1 && guard < 10) begin
                    out_ready = (guard >= 6) ? 1'b1 : 1'($urandom_range(0, 1));
                    tick();
                    guard++;
                    if (out_valid === 1'b1) begin
                        vectors++;
                        if (sum !== hold) begin miscompares++; $display("FAIL b2b_stall_sum a=%0d b=%0d: got %0d want %0d", ai, bi, sum, hold); end
                    end
                end
                vectors++;
                if (out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_handshake a=%0d b=%0d: out_valid got %b want 0", ai, bi, out_valid); end
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        out_ready = 1'b0;
        test_reset();
        test_zero();
        test_small();
        test_carry_chain();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
